instr_fetch: RTL and testbench

Instruction fetch unit that drives the combinational instruction memory's address port and consumes its 16-bit instruction output. It owns the program counter and walks it in word-aligned 4-byte steps. Each fetched {pc, instruction} pair goes into a 2-entry buffer, which decode drains through a valid/ready handshake. It sits between the instruction memory and the decode stage, accepts branch redirects, and stops fetching on misaligned or out-of-bounds PCs.

---
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch unit: walks the PC over a combinational instruction memory into a 2-entry buffer.
// Entry visible one cycle after fetch; fetch stalls only when full and not draining.
module instr_fetch #(
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_pc
);

  typedef enum logic {RUN, STOP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [1:0]          count;
  logic                rd_ptr;
  logic                wr_ptr;
  logic [ADDR_W-1:0]   pc_buf  [2];
  logic [INSTR_W-1:0]  ins_buf [2];
  logic [ADDR_W:0]     pc_last;
  logic                pc_bad;
  logic                deq;
  logic                enq;

  // One extra bit so pc + 3 cannot wrap back into range.
  assign pc_last = {1'b0, pc} + (ADDR_W+1)'(3);
  assign pc_bad  = (pc[1:0] != 2'b00) || (pc_last >= (ADDR_W+1)'(MEM_BYTES));

  assign out_valid = (count != 2'd0);
  assign deq       = out_valid && out_ready;
  assign out_instr = ins_buf[rd_ptr];
  assign out_pc    = pc_buf[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = RUN;
    else if (state == RUN && pc_bad)
      state_nxt = STOP;
  end

  always_comb begin
    imem_addr = '0;
    fault     = 1'b0;
    enq       = 1'b0;
    if (state == RUN) begin
      imem_addr = pc;
      enq       = !pc_bad && !redirect_valid && (count < 2'd2 || deq);
    end else begin
      fault = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fault_pc   <= '0;
      pc_buf[0]  <= '0;
      pc_buf[1]  <= '0;
      ins_buf[0] <= '0;
      ins_buf[1] <= '0;
    end else if (redirect_valid) begin
      // A same-cycle head handshake is consumed; everything else is flushed.
      pc     <= redirect_pc;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) begin
        pc_buf[wr_ptr]  <= pc;
        ins_buf[wr_ptr] <= imem_instr;
        wr_ptr          <= ~wr_ptr;
        pc              <= pc + ADDR_W'(4);
      end
      if (deq)
        rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (state == RUN && pc_bad)
        fault_pc <= pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected {pc, instr} pairs are queued by the
// stimulus and popped by an independent monitor on every output handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;
  logic [15:0] fault_pc;

  logic [15:0] mem [0:255];
  logic [31:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instr_fetch #(
    .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .MEM_BYTES(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] exp_instr(input logic [15:0] p);
    case (p)
      16'd0:   return 16'h1111;
      16'd4:   return 16'h2222;
      16'd8:   return 16'h3333;
      16'd12:  return 16'h4444;
      default: return 16'hA000 + 16'(p[9:2]);
    endcase
  endfunction

  task automatic push_exp(input logic [15:0] p);
    exp_q.push_back({p, exp_instr(p)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with reset low (cycle R).
  task automatic do_reset();
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fault",     32'(fault),     32'd0);
    check("rst_fault_pc",  32'(fault_pc),  32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual pc=%h instr=%h required none", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_entry", {out_pc, out_instr}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Reset state, then in-order stream at full throughput.
    reset = 1'b1;
    tick();
    check("rst_out_pc",    32'(out_pc),    32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    do_reset();
    out_ready = 1'b1;
    push_exp(16'd0); push_exp(16'd4); push_exp(16'd8); push_exp(16'd12);
    check("first_cycle_empty", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("stream_addr", 32'(imem_addr), 32'(4 * k));
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_fault", 32'(fault), 32'd0);
    end
    tick();

    // Backpressure: full buffer holds pc and head.
    do_reset();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("full_addr",  32'(imem_addr), 32'd8);
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_head",  {out_pc, out_instr}, {16'd0, 16'h1111});
      tick();
    end
    out_ready = 1'b1;
    push_exp(16'd0); push_exp(16'd4); push_exp(16'd8);
    tick();
    tick();
    tick();

    // Redirect while the head (pc 4) handshakes; pc 8 is dropped.
    do_reset();
    tick();
    tick();
    out_ready = 1'b1;
    push_exp(16'd0); push_exp(16'd4);
    tick();
    check("pre_redirect_head", 32'(out_pc), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("redirect_bubble", 32'(out_valid), 32'd0);
    check("redirect_addr",   32'(imem_addr), 32'h40);
    for (int p = 64; p <= 1020; p += 4) push_exp(16'(p));
    tick();
    check("redirect_target_valid", 32'(out_valid), 32'd1);

    // Run to the end of memory.
    n = 0;
    while (!(out_valid && out_pc == 16'd1020) && n < 400) begin
      tick();
      n++;
    end
    check("reach_last_word", 32'(out_valid && out_pc == 16'd1020), 32'd1);
    check("last_word_no_fault", 32'(fault), 32'd0);
    tick();
    check("end_fault",    32'(fault),     32'd1);
    check("end_fault_pc", 32'(fault_pc),  32'd1024);
    check("end_addr",     32'(imem_addr), 32'd0);
    check("end_valid",    32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stop_hold_valid", 32'(out_valid), 32'd0);
    end

    // Recover from STOP by redirect, then redirect to a misaligned PC.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    check("resume_fault", 32'(fault), 32'd0);
    check("resume_addr",  32'(imem_addr), 32'd0);
    push_exp(16'd0); push_exp(16'd4);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0012;
    tick();
    redirect_valid = 1'b0;
    check("mis_addr",  32'(imem_addr), 32'h12);
    check("mis_fault_early", 32'(fault), 32'd0);
    tick();
    check("mis_fault",    32'(fault),     32'd1);
    check("mis_fault_pc", 32'(fault_pc),  32'h12);
    check("mis_valid",    32'(out_valid), 32'd0);

    // Reset overrides buffered entries and a simultaneous redirect.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("prefill_addr", 32'(imem_addr), 32'd8);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    check("rst_mid_valid",    32'(out_valid), 32'd0);
    check("rst_mid_fault",    32'(fault),     32'd0);
    check("rst_mid_addr",     32'(imem_addr), 32'd0);
    check("rst_mid_fault_pc", 32'(fault_pc),  32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_exp(16'd0); push_exp(16'd4);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
